// File: rtl/ccff_chain_loader.sv
// Streams configuration words MSB-first into a ccff chain and pulses done after CHAIN_LEN bits.
// Define CCFF_LOADER_CRC_EN to fold the displaced ccff_tail bits into a readback CRC-8.
module ccff_chain_loader #(
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned CHAIN_LEN = 20,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [7:0]        readback_crc
);

  localparam int unsigned BUF_W = $clog2(WORD_W + 1);
  localparam int unsigned CMP_W = (CNT_W > BUF_W) ? CNT_W : BUF_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_nx;
  logic [WORD_W-1:0] shreg_q;
  logic [BUF_W-1:0]  buf_cnt_q;
  logic [CNT_W-1:0]  bits_left_q;
  logic              busy_q;
  logic              done_q;
  logic              load_go;
  logic              in_load;
  logic              shift;
  logic              last_shift;
  logic              buf_low;
  logic              accept;

  // Datapath decode: a shift happens whenever the buffer still holds bits in LOAD
  assign in_load    = (state_q == S_LOAD);
  assign shift      = in_load && (buf_cnt_q != '0);
  assign last_shift = shift && (bits_left_q == CNT_W'(1));
  assign buf_low    = (buf_cnt_q == '0) || ((buf_cnt_q == BUF_W'(1)) && shift);
  assign word_ready = in_load && buf_low && (CMP_W'(bits_left_q) > CMP_W'(buf_cnt_q));
  assign accept     = word_ready && word_valid;

  assign ccff_en   = shift;
  assign ccff_head = shreg_q[WORD_W-1];
  assign busy      = busy_q;
  assign done      = done_q;

  // Next-state logic
  always_comb begin
    state_nx = state_q;
    load_go  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_nx = S_LOAD;
          load_go  = 1'b1;
        end
      end
      S_LOAD: begin
        if (last_shift) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nx;
      busy_q  <= (state_nx == S_LOAD);
      done_q  <= (state_nx == S_DONE);
    end
  end

  // Word buffer and counters; the last shift discards any unused LSBs of the final word
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      shreg_q     <= '0;
      buf_cnt_q   <= '0;
      bits_left_q <= '0;
    end else if (load_go) begin
      shreg_q     <= '0;
      buf_cnt_q   <= '0;
      bits_left_q <= CNT_W'(CHAIN_LEN);
    end else if (last_shift) begin
      shreg_q     <= '0;
      buf_cnt_q   <= '0;
      bits_left_q <= '0;
    end else if (accept) begin
      shreg_q   <= word_data;
      buf_cnt_q <= BUF_W'(WORD_W);
      if (shift) begin
        bits_left_q <= bits_left_q - CNT_W'(1);
      end
    end else if (shift) begin
      shreg_q     <= {shreg_q[WORD_W-2:0], 1'b0};
      buf_cnt_q   <= buf_cnt_q - BUF_W'(1);
      bits_left_q <= bits_left_q - CNT_W'(1);
    end
  end

`ifdef CCFF_LOADER_CRC_EN
  localparam logic [7:0] CRC_POLY = 8'h07;

  logic [7:0] crc_q;
  logic [7:0] crc_nx;

  // Bitwise MSB-first CRC-8 step over the bit leaving the chain
  always_comb begin
    crc_nx = {crc_q[6:0], 1'b0};
    if (crc_q[7] ^ ccff_tail) begin
      crc_nx = crc_nx ^ CRC_POLY;
    end
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      crc_q <= 8'h00;
    end else if (load_go) begin
      crc_q <= 8'h00;
    end else if (shift) begin
      crc_q <= crc_nx;
    end
  end

  assign readback_crc = crc_q;
`else
  logic unused_tail;
  assign unused_tail  = ccff_tail;
  assign readback_crc = 8'h00;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench for ccff_chain_loader: driver queues expected head bits and load results,
// a negedge monitor pops and compares them against a behavioural chain model.
module tb_ccff_chain_loader;

  localparam int unsigned WORD_W    = 8;
  localparam int unsigned CHAIN_LEN = 20;
  localparam int unsigned NUM_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;

  typedef struct {
    int                   exp_cycle;
    logic [CHAIN_LEN-1:0] img;
    logic [7:0]           crc;
  } done_exp_t;

  logic              prog_clk = 1'b0;
  logic              pReset = 1'b1;
  logic              start = 1'b0;
  logic              word_valid = 1'b0;
  logic [WORD_W-1:0] word_data = '0;
  logic              word_ready;
  logic              ccff_head;
  logic              ccff_en;
  logic              ccff_tail;
  logic              busy;
  logic              done;
  logic [7:0]        readback_crc;

  ccff_chain_loader #(
    .WORD_W   (WORD_W),
    .CHAIN_LEN(CHAIN_LEN)
  ) dut (
    .prog_clk    (prog_clk),
    .pReset      (pReset),
    .start       (start),
    .word_valid  (word_valid),
    .word_data   (word_data),
    .word_ready  (word_ready),
    .ccff_head   (ccff_head),
    .ccff_en     (ccff_en),
    .ccff_tail   (ccff_tail),
    .busy        (busy),
    .done        (done),
    .readback_crc(readback_crc)
  );

  always #5 prog_clk = ~prog_clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Chain model: the external ccff chain, shifting on each enabled edge
  logic [CHAIN_LEN-1:0] chain = '0;
  logic                 preload_req = 1'b0;
  logic [CHAIN_LEN-1:0] preload_val = '0;
  logic                 cnt_clr = 1'b0;
  int                   en_cnt = 0;
  int                   cyc = 0;
  int                   start_cyc = 0;

  always @(posedge prog_clk) begin
    cyc <= cyc + 1;
    if (preload_req) chain <= preload_val;
    else if (ccff_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
    if (cnt_clr) en_cnt <= 0;
    else if (ccff_en) en_cnt <= en_cnt + 1;
  end

  assign ccff_tail = chain[CHAIN_LEN-1];

  // CRC-8 (x^8+x^2+x+1) as polynomial long division of the displaced bit stream
  function automatic logic [7:0] crc_ref(input logic [CHAIN_LEN-1:0] old);
    bit         m [CHAIN_LEN+8];
    logic [8:0] poly;
    logic [7:0] r;
    poly = 9'h107;
    for (int i = 0; i < CHAIN_LEN; i++) m[i] = old[CHAIN_LEN-1-i];
    for (int i = CHAIN_LEN; i < CHAIN_LEN + 8; i++) m[i] = 1'b0;
    for (int i = 0; i < CHAIN_LEN; i++) begin
      if (m[i]) begin
        for (int j = 0; j < 9; j++) m[i+j] = m[i+j] ^ poly[8-j];
      end
    end
    for (int k = 0; k < 8; k++) r[7-k] = m[CHAIN_LEN+k];
    return r;
  endfunction

  logic      bitq [$];
  done_exp_t doneq [$];
  done_exp_t mon_e;

  // Monitor: compares every shifted bit and every load completion
  always @(negedge prog_clk) begin
    if (pReset) begin
      if (ccff_en) begin
        if (bitq.size() == 0) check("spurious_shift", 32'(ccff_en), 32'(0));
        else check("ccff_head", 32'(ccff_head), 32'(bitq.pop_front()));
      end
      if (done) begin
        if (doneq.size() == 0) begin
          check("spurious_done", 32'(done), 32'(0));
        end else begin
          mon_e = doneq.pop_front();
          check("en_count", 32'(en_cnt), 32'(CHAIN_LEN));
          check("bits_unshifted", 32'(bitq.size()), 32'(0));
          if (mon_e.exp_cycle >= 0) check("done_cycle", 32'(cyc - start_cyc), 32'(mon_e.exp_cycle));
          check("chain_image", 32'(chain), 32'(mon_e.img));
          check("readback_crc", 32'(readback_crc), 32'(mon_e.crc));
        end
      end
    end
  end

  logic [WORD_W-1:0] word_q [$];

  task automatic preload(input logic [CHAIN_LEN-1:0] v);
    preload_val = v;
    preload_req = 1'b1;
    @(posedge prog_clk); #1;
    preload_req = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_word_ready", 32'(word_ready), 32'(0));
    check("rst_ccff_en", 32'(ccff_en), 32'(0));
    check("rst_ccff_head", 32'(ccff_head), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_crc", 32'(readback_crc), 32'(0));
  endtask

  // mode 0: valid held (plus a stray start in LOAD); 1: starve 5 ready cycles before word 1; 2: random valid
  task automatic run_load(input int mode, input int abort_bits, input int exp_cycle);
    logic [CHAIN_LEN-1:0] img;
    logic [WORD_W-1:0]    wd;
    done_exp_t            e;
    int                   nb, widx, withheld, accepted, cycles;
    logic                 acc, got_done;
    while (word_q.size() < NUM_WORDS + 2) word_q.push_back(WORD_W'($urandom));
    nb = 0;
    img = '0;
    for (int w = 0; w < int'(NUM_WORDS); w++) begin
      wd = word_q[w];
      for (int b = WORD_W - 1; b >= 0; b--) begin
        if (nb < int'(CHAIN_LEN)) begin
          bitq.push_back(wd[b]);
          img[CHAIN_LEN-1-nb] = wd[b];
          nb++;
        end
      end
    end
    e.exp_cycle = exp_cycle;
    e.img = img;
`ifdef CCFF_LOADER_CRC_EN
    e.crc = crc_ref(chain);
`else
    e.crc = 8'h00;
`endif
    if (abort_bits == 0) doneq.push_back(e);
    start = 1'b1;
    cnt_clr = 1'b1;
    start_cyc = cyc;
    @(posedge prog_clk); #1;
    start = 1'b0;
    cnt_clr = 1'b0;
    check("busy_cycle1", 32'(busy), 32'(1));
    check("ready_cycle1", 32'(word_ready), 32'(1));
    widx = 0; withheld = 0; accepted = 0; cycles = 0; got_done = 1'b0;
    while (!got_done && cycles < 200) begin
      word_data = word_q[widx];
      if (mode == 1 && widx == 1 && withheld < 5) word_valid = 1'b0;
      else if (mode == 2) word_valid = ($urandom_range(0, 3) != 0);
      else word_valid = 1'b1;
      start = (mode == 0 && cycles == 3);
      @(negedge prog_clk);
      acc = word_valid && word_ready;
      if (mode == 1 && widx == 1 && !word_valid && word_ready) withheld++;
      got_done = done;
      if (done) check("busy_in_done", 32'(busy), 32'(0));
      if (abort_bits > 0 && en_cnt == abort_bits) begin
        #1 pReset = 1'b0;
        #1;
        check_reset_outputs();
        bitq.delete();
        doneq.delete();
        word_q.delete();
        word_valid = 1'b0;
        start = 1'b0;
        @(posedge prog_clk); #1 pReset = 1'b1;
        @(posedge prog_clk); #1;
        return;
      end
      @(posedge prog_clk); #1;
      if (acc) begin
        accepted++;
        if (widx < word_q.size() - 1) widx++;
      end
      cycles++;
    end
    word_valid = 1'b0;
    start = 1'b0;
    check("done_seen", 32'(got_done), 32'(1));
    if (!got_done) begin
      bitq.delete();
      doneq.delete();
    end
    check("words_accepted", 32'(accepted), 32'(NUM_WORDS));
    check("idle_after_done_busy", 32'(busy), 32'(0));
    check("done_one_cycle", 32'(done), 32'(0));
    check("crc_held", 32'(readback_crc), 32'(e.crc));
    word_q.delete();
  endtask

  initial begin
    #3 pReset = 1'b0;
    #1;
    check_reset_outputs();
    repeat (3) @(posedge prog_clk);
    #1 pReset = 1'b1;
    preload('0);

    // stream words offered in IDLE must be refused
    word_valid = 1'b1;
    word_data = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge prog_clk);
      check("idle_ready", 32'(word_ready), 32'(0));
      check("idle_busy", 32'(busy), 32'(0));
      check("idle_en", 32'(ccff_en), 32'(0));
    end
    @(posedge prog_clk); #1;
    word_valid = 1'b0;

    word_q = '{8'hA5, 8'h3C, 8'hF0, 8'h5A};
    run_load(0, 0, CHAIN_LEN + 2);
    run_load(1, 0, CHAIN_LEN + 7);
    run_load(0, 10, 0);
    run_load(0, 0, CHAIN_LEN + 2);
    preload('1);
    run_load(0, 0, CHAIN_LEN + 2);
    for (int t = 0; t < 6; t++) run_load(2, 0, -1);
    repeat (3) @(posedge prog_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
